// File: rtl/div_core_arbiter_if.sv
// Requester-side and divider-core-side signal bundle for div_core_arbiter.
// slave is the arbiter's view; master is the requesters/core environment view.
interface div_core_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLZ_W      = $clog2(DATA_WIDTH)
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_dividend;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0][CLZ_W-1:0]      req_dividend_clz;
    logic [NUM_REQ-1:0][CLZ_W-1:0]      req_divisor_clz;
    logic [NUM_REQ-1:0]                 req_divisor_is_zero;
    logic [NUM_REQ-1:0]                 resp_valid;
    logic [NUM_REQ-1:0]                 resp_ack;
    logic [DATA_WIDTH-1:0]              resp_quotient;
    logic [DATA_WIDTH-1:0]              resp_remainder;
    logic                               core_start;
    logic [DATA_WIDTH-1:0]              core_dividend;
    logic [DATA_WIDTH-1:0]              core_divisor;
    logic [CLZ_W-1:0]                   core_dividend_clz;
    logic [CLZ_W-1:0]                   core_divisor_clz;
    logic                               core_divisor_is_zero;
    logic                               core_done;
    logic [DATA_WIDTH-1:0]              core_quotient;
    logic [DATA_WIDTH-1:0]              core_remainder;

    modport slave (
        input  req_valid, req_dividend, req_divisor, req_dividend_clz, req_divisor_clz,
               req_divisor_is_zero, resp_ack, core_done, core_quotient, core_remainder,
        output req_ready, resp_valid, resp_quotient, resp_remainder, core_start,
               core_dividend, core_divisor, core_dividend_clz, core_divisor_clz,
               core_divisor_is_zero
    );

    modport master (
        output req_valid, req_dividend, req_divisor, req_dividend_clz, req_divisor_clz,
               req_divisor_is_zero, resp_ack, core_done, core_quotient, core_remainder,
        input  req_ready, resp_valid, resp_quotient, resp_remainder, core_start,
               core_dividend, core_divisor, core_dividend_clz, core_divisor_clz,
               core_divisor_is_zero
    );
endinterface

// File: rtl/div_core_arbiter.sv
// Round-robin sharing of one iterative divider core among NUM_REQ requesters.
// Optional last-result cache: define DIV_ARB_RESULT_CACHE_EN.
module div_core_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLZ_W      = $clog2(DATA_WIDTH)
) (
    input logic               clk,
    input logic               rst,
    div_core_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, HOLD} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
    logic [CLZ_W-1:0]       dvd_clz_q, dvd_clz_d, dvs_clz_q, dvs_clz_d;
    logic                   dz_q, dz_d;
    logic [DATA_WIDTH-1:0]  quo_q, quo_d, rem_q, rem_d;
    logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic                   core_start_q, core_start_d;
    logic [IDX_W-1:0]       grant_idx_c, idx_c;
    logic                   grant_found_c, accept_c;
`ifdef DIV_ARB_RESULT_CACHE_EN
    logic                   hit_c, hit_q, hit_d;
    logic                   cache_valid_q, cache_valid_d;
    logic [DATA_WIDTH-1:0]  cache_dvd_q, cache_dvd_d, cache_dvs_q, cache_dvs_d;
    logic [DATA_WIDTH-1:0]  cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;
`endif

    // Round-robin pick starting one past the last grant; accept only in a window.
    always_comb begin
        grant_idx_c   = '0;
        grant_found_c = 1'b0;
        idx_c         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_c = IDX_W'((32'(last_grant_q) + 32'd1 + k) % NUM_REQ);
            if (!grant_found_c && bus.req_valid[idx_c]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = idx_c;
            end
        end
        accept_c = grant_found_c &&
                   ((state_q == IDLE) || ((state_q == HOLD) && bus.resp_ack[owner_q]));
        bus.req_ready = '0;
        if (accept_c) bus.req_ready[grant_idx_c] = 1'b1;
    end

`ifdef DIV_ARB_RESULT_CACHE_EN
    assign hit_c = cache_valid_q &&
                   (bus.req_dividend[grant_idx_c] == cache_dvd_q) &&
                   (bus.req_divisor[grant_idx_c]  == cache_dvs_q);
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        dvd_clz_d    = dvd_clz_q;
        dvs_clz_d    = dvs_clz_q;
        dz_d         = dz_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        core_start_d = 1'b0;
        resp_valid_d = '0;
`ifdef DIV_ARB_RESULT_CACHE_EN
        hit_d         = hit_q;
        cache_valid_d = cache_valid_q;
        cache_dvd_d   = cache_dvd_q;
        cache_dvs_d   = cache_dvs_q;
        cache_quo_d   = cache_quo_q;
        cache_rem_d   = cache_rem_q;
`endif
        case (state_q)
            IDLE: if (accept_c) state_d = LAUNCH;
            LAUNCH: begin
                state_d = BUSY;
`ifdef DIV_ARB_RESULT_CACHE_EN
                if (hit_q) begin
                    state_d = HOLD;
                    quo_d   = cache_quo_q;
                    rem_d   = cache_rem_q;
                end
`endif
            end
            BUSY: if (bus.core_done) begin
                state_d = HOLD;
                quo_d   = bus.core_quotient;
                rem_d   = bus.core_remainder;
`ifdef DIV_ARB_RESULT_CACHE_EN
                cache_valid_d = 1'b1;
                cache_dvd_d   = dvd_q;
                cache_dvs_d   = dvs_q;
                cache_quo_d   = bus.core_quotient;
                cache_rem_d   = bus.core_remainder;
`endif
            end
            HOLD: if (bus.resp_ack[owner_q]) state_d = accept_c ? LAUNCH : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept_c) begin
            owner_d      = grant_idx_c;
            last_grant_d = grant_idx_c;
            dvd_d        = bus.req_dividend[grant_idx_c];
            dvs_d        = bus.req_divisor[grant_idx_c];
            dvd_clz_d    = bus.req_dividend_clz[grant_idx_c];
            dvs_clz_d    = bus.req_divisor_clz[grant_idx_c];
            dz_d         = bus.req_divisor_is_zero[grant_idx_c];
`ifdef DIV_ARB_RESULT_CACHE_EN
            hit_d        = hit_c;
            core_start_d = !hit_c;
`else
            core_start_d = 1'b1;
`endif
        end
        if (state_d == HOLD) resp_valid_d[owner_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            dvd_q        <= '0;
            dvs_q        <= '0;
            dvd_clz_q    <= '0;
            dvs_clz_q    <= '0;
            dz_q         <= 1'b0;
            quo_q        <= '0;
            rem_q        <= '0;
            resp_valid_q <= '0;
            core_start_q <= 1'b0;
`ifdef DIV_ARB_RESULT_CACHE_EN
            hit_q         <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_dvd_q   <= '0;
            cache_dvs_q   <= '0;
            cache_quo_q   <= '0;
            cache_rem_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            dvd_clz_q    <= dvd_clz_d;
            dvs_clz_q    <= dvs_clz_d;
            dz_q         <= dz_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            resp_valid_q <= resp_valid_d;
            core_start_q <= core_start_d;
`ifdef DIV_ARB_RESULT_CACHE_EN
            hit_q         <= hit_d;
            cache_valid_q <= cache_valid_d;
            cache_dvd_q   <= cache_dvd_d;
            cache_dvs_q   <= cache_dvs_d;
            cache_quo_q   <= cache_quo_d;
            cache_rem_q   <= cache_rem_d;
`endif
        end
    end

    assign bus.resp_valid           = resp_valid_q;
    assign bus.resp_quotient        = quo_q;
    assign bus.resp_remainder       = rem_q;
    assign bus.core_start           = core_start_q;
    assign bus.core_dividend        = dvd_q;
    assign bus.core_divisor         = dvs_q;
    assign bus.core_dividend_clz    = dvd_clz_q;
    assign bus.core_divisor_clz     = dvs_clz_q;
    assign bus.core_divisor_is_zero = dz_q;
endmodule

// File: tb/tb_div_core_arbiter.sv
// Directed bench for div_core_arbiter with a 4-cycle divider core model and result scoreboard.
module tb_div_core_arbiter;
    localparam int unsigned NR = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;
    localparam int unsigned IW = 1;
    localparam int CORE_LAT = 4;
`ifdef DIV_ARB_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic spurious_done;
    int   core_cnt;

    div_core_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CLZ_W(CW)) bus ();
    div_core_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CLZ_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [DW-1:0] q; logic [DW-1:0] r; } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Divider core model: done pulse CORE_LAT cycles after start, computed from core operands.
    initial begin
        logic [DW-1:0] cq, cr;
        bus.core_done = 1'b0;
        bus.core_quotient = '0;
        bus.core_remainder = '0;
        core_cnt = 0;
        cq = '0;
        cr = '0;
        forever begin
            @(posedge clk);
            #3;
            bus.core_done = spurious_done;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    bus.core_done = 1'b1;
                    bus.core_quotient = cq;
                    bus.core_remainder = cr;
                end
            end
            if (bus.core_start) begin
                cq = (bus.core_divisor == 0) ? '1 : bus.core_dividend / bus.core_divisor;
                cr = (bus.core_divisor == 0) ? bus.core_dividend : bus.core_dividend % bus.core_divisor;
                core_cnt = CORE_LAT;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] clz(input logic [DW-1:0] v);
        int n = 0;
        for (int i = int'(DW) - 1; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return CW'(n);
    endfunction

    task automatic drive(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_dividend[IW'(id)] = a;
        bus.req_divisor[IW'(id)] = b;
        bus.req_dividend_clz[IW'(id)] = clz(a);
        bus.req_divisor_clz[IW'(id)] = clz(b);
        bus.req_divisor_is_zero[IW'(id)] = (b == 0);
        bus.req_valid[IW'(id)] = 1'b1;
    endtask

    task automatic push_exp(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        e.id = id;
        e.q = a / b;
        e.r = a % b;
        sb.push_back(e);
    endtask

    task automatic wait_resp(input int maxc, output int waited, output int id);
        exp_t e;
        waited = 0;
        id = 0;
        while (bus.resp_valid == '0 && waited < maxc) begin
            tick();
            waited++;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        id = e.id;
        chk("resp_valid", 64'(bus.resp_valid), 64'd1 << e.id);
        chk("resp_q", 64'(bus.resp_quotient), 64'(e.q));
        chk("resp_r", 64'(bus.resp_remainder), 64'(e.r));
    endtask

    task automatic ack(input int id);
        bus.resp_ack[IW'(id)] = 1'b1;
        tick();
        bus.resp_ack = '0;
    endtask

    initial begin
        int w, id;
        rst = 1'b1;
        spurious_done = 1'b0;
        bus.req_valid = '0;
        bus.resp_ack = '0;
        bus.req_dividend = '0;
        bus.req_divisor = '0;
        bus.req_dividend_clz = '0;
        bus.req_divisor_clz = '0;
        bus.req_divisor_is_zero = '0;
        repeat (3) tick();
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_core_start", 64'(bus.core_start), 64'd0);
        chk("rst_quotient", 64'(bus.resp_quotient), 64'd0);
        chk("rst_core_dvd", 64'(bus.core_dividend), 64'd0);
        rst = 1'b0;
        tick();

        // Single operation: 100/7 from requester 0.
        drive(0, 100, 7);
        push_exp(0, 100, 7);
        #1;
        chk("single_grant", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = '0;
        chk("single_start", 64'(bus.core_start), 64'd1);
        chk("single_core_dvd", 64'(bus.core_dividend), 64'd100);
        chk("single_core_dvs", 64'(bus.core_divisor), 64'd7);
        chk("single_core_clz", 64'(bus.core_dividend_clz), 64'd25);
        chk("single_core_dz", 64'(bus.core_divisor_is_zero), 64'd0);
        tick();
        chk("single_start_pulse", 64'(bus.core_start), 64'd0);
        wait_resp(20, w, id);
        chk("single_latency", 64'(w), 64'(CORE_LAT));
        ack(id);
        chk("single_resp_clear", 64'(bus.resp_valid), 64'd0);

        // Simultaneous requests after reset: order 0,1,0,1 with back-to-back issue.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 6, 3);
        drive(1, 9, 2);
        push_exp(0, 6, 3);
        push_exp(1, 9, 2);
        push_exp(0, 6, 3);
        push_exp(1, 9, 2);
        for (int i = 0; i < 4; i++) begin
            wait_resp(30, w, id);
            if (i == 3) bus.req_valid = '0;
            bus.resp_ack[IW'(id)] = 1'b1;
            #1;
            if (i < 3) chk("rr_grant_in_ack", 64'(bus.req_ready), 64'd1 << (1 - id));
            tick();
            bus.resp_ack = '0;
            if (i < 3) chk("rr_b2b_start", 64'(bus.core_start), 64'd1);
        end

        // Backpressure: ack withheld 10 cycles with requester 1 pending.
        drive(0, 50, 6);
        push_exp(0, 50, 6);
        tick();
        bus.req_valid = '0;
        wait_resp(30, w, id);
        drive(1, 77, 5);
        push_exp(1, 77, 5);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
            chk("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
            chk("bp_q_stable", 64'(bus.resp_quotient), 64'd8);
            chk("bp_r_stable", 64'(bus.resp_remainder), 64'd2);
            tick();
        end
        bus.resp_ack[0] = 1'b1;
        #1;
        chk("bp_grant_on_ack", 64'(bus.req_ready), 64'd2);
        tick();
        bus.resp_ack = '0;
        bus.req_valid = '0;
        chk("bp_b2b_start", 64'(bus.core_start), 64'd1);
        chk("bp_b2b_dvd", 64'(bus.core_dividend), 64'd77);
        wait_resp(30, w, id);
        ack(id);

        // Reset two cycles after core_start; stale core_done follows.
        drive(0, 200, 9);
        tick();
        bus.req_valid = '0;
        chk("rmb_start", 64'(bus.core_start), 64'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmb_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rmb_core_start", 64'(bus.core_start), 64'd0);
        chk("rmb_core_dvd", 64'(bus.core_dividend), 64'd0);
        chk("rmb_quotient", 64'(bus.resp_quotient), 64'd0);
        chk("rmb_ready", 64'(bus.req_ready), 64'd0);
        repeat (4) begin
            tick();
            chk("rmb_stale_done", 64'({bus.resp_valid, bus.core_start}), 64'd0);
        end
        drive(1, 30, 4);
        push_exp(1, 30, 4);
        tick();
        bus.req_valid = '0;
        chk("rmb_next_start", 64'(bus.core_start), 64'd1);
        wait_resp(30, w, id);
        chk("rmb_next_latency", 64'(w), 64'(CORE_LAT + 1));
        ack(id);

        // Stray ack and spurious core_done in IDLE, then non-owner ack in HOLD.
        bus.resp_ack = '1;
        spurious_done = 1'b1;
        tick();
        bus.resp_ack = '0;
        spurious_done = 1'b0;
        chk("stray_idle", 64'({bus.resp_valid, bus.core_start, bus.req_ready}), 64'd0);
        chk("stray_q_kept", 64'(bus.resp_quotient), 64'd7);
        drive(0, 12, 5);
        push_exp(0, 12, 5);
        tick();
        bus.req_valid = '0;
        wait_resp(30, w, id);
        bus.resp_ack[1] = 1'b1;
        tick();
        tick();
        bus.resp_ack = '0;
        chk("nonowner_ack_rv", 64'(bus.resp_valid), 64'd1);
        chk("nonowner_ack_q", 64'(bus.resp_quotient), 64'd2);
        ack(0);
        chk("owner_ack_rv", 64'(bus.resp_valid), 64'd0);

        // Repeat 100/7 from requester 1 (cache hit when enabled), then 100/8.
        drive(0, 100, 7);
        push_exp(0, 100, 7);
        tick();
        bus.req_valid = '0;
        chk("cache_fill_start", 64'(bus.core_start), 64'd1);
        wait_resp(30, w, id);
        ack(id);
        drive(1, 100, 7);
        push_exp(1, 100, 7);
        tick();
        bus.req_valid = '0;
        chk("cache_repeat_start", 64'(bus.core_start), CACHE ? 64'd0 : 64'd1);
        wait_resp(30, w, id);
        chk("cache_repeat_latency", 64'(w), CACHE ? 64'd1 : 64'(CORE_LAT + 1));
        ack(id);
        drive(1, 100, 8);
        push_exp(1, 100, 8);
        tick();
        bus.req_valid = '0;
        chk("cache_miss_start", 64'(bus.core_start), 64'd1);
        wait_resp(30, w, id);
        ack(id);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
